// File: rtl/three_input_gate_test_sequencer_pkg.sv
// three_input_gate_test_sequencer_pkg: shared state encoding, vector count and gate truth tables.
package three_input_gate_test_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam logic [2:0] LAST_IDX = 3'(NUM_VECTORS - 1);

  localparam logic [7:0] NOR3_TRUTH  = 8'h01;
  localparam logic [7:0] NAND3_TRUTH = 8'h7F;
  localparam logic [7:0] AND3_TRUTH  = 8'h80;
  localparam logic [7:0] OR3_TRUTH   = 8'hFE;

  // Error count never exceeds the number of vectors.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'(NUM_VECTORS)) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/three_input_gate_test_sequencer_hold_timer.sv
// three_input_gate_test_sequencer_hold_timer: loadable 4-bit down-counter with terminal-count flag.
module three_input_gate_test_sequencer_hold_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [3:0] i_value,
  output logic       o_tc
);

  logic [3:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= 4'd0;
    else if (i_load) r_count <= i_value;
    else if (i_en && !o_tc) r_count <= r_count - 4'd1;
  end

  assign o_tc = (r_count == 4'd0);

endmodule

// File: rtl/three_input_gate_test_sequencer.sv
// three_input_gate_test_sequencer: steps a 3-input gate through all 8 vectors and checks it against a truth table.
module three_input_gate_test_sequencer
  import three_input_gate_test_sequencer_pkg::*;
#(
  parameter int         HOLD_CYCLES  = 2,
  parameter logic [7:0] EXPECT_TRUTH = NOR3_TRUTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_d,
  output logic       drive_a,
  output logic       drive_b,
  output logic       drive_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask
);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [2:0] r_drive, w_drive_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_pass, w_pass_nxt;
  logic [3:0] r_err, w_err_nxt;
  logic [7:0] r_mask, w_mask_nxt;
  logic       w_accept, w_mismatch, w_tc, w_load, w_run_nxt;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_mismatch = (r_state == ST_SAMPLE) && (dut_d != EXPECT_TRUTH[r_idx]);
  assign w_load     = w_accept || ((r_state == ST_SAMPLE) && (r_idx != LAST_IDX));

  three_input_gate_test_sequencer_hold_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_en    (r_state == ST_APPLY),
    .i_value (4'(HOLD_CYCLES - 1)),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_nxt = ST_APPLY;
        w_idx_nxt   = 3'd0;
      end
      ST_APPLY: if (w_tc) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (r_idx == LAST_IDX) w_state_nxt = ST_FINISH;
      else begin
        w_state_nxt = ST_APPLY;
        w_idx_nxt   = r_idx + 3'd1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    w_run_nxt   = (w_state_nxt == ST_APPLY) || (w_state_nxt == ST_SAMPLE);
    w_drive_nxt = w_run_nxt ? w_idx_nxt : 3'd0;
    w_busy_nxt  = w_run_nxt;
    w_done_nxt  = (w_state_nxt == ST_FINISH);
    w_err_nxt   = w_accept ? 4'd0 : w_mismatch ? sat_inc(r_err) : r_err;
    w_mask_nxt  = w_accept ? 8'd0 : w_mismatch ? (r_mask | (8'd1 << r_idx)) : r_mask;
    w_pass_nxt  = w_accept ? 1'b0 : w_done_nxt ? (w_err_nxt == 4'd0) : r_pass;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drive <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 4'd0;
      r_mask  <= 8'd0;
    end else begin
      r_drive <= w_drive_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  assign {drive_a, drive_b, drive_c} = r_drive;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_mask = r_mask;

endmodule
